// File: rtl/and_cnt.sv
// and_cnt: AND-popcount stage following cnt1.
// The first complete vector after reset or reload is kept as reference A
// together with its popcount (CntA). Each following vector B is ANDed with A
// beat by beat, and popcount(A & B) is accumulated. One {CntA, CntB, CntAB}
// result per B vector is emitted for the similarity stage.
//
// Ports:
//   clk, rstn      clock (posedge) and synchronous active-low reset
//   up_SubVector   beat data from cnt1
//   up_Valid/Ready beat handshake
//   up_Cnt         popcount of the whole vector, valid with up_CntNew
//   up_CntNew      last beat of a vector
//   ref_Reload     at the next vector boundary, the following vector becomes A
//   dn_CntA/B/AB   result counts
//   dn_Valid/Ready result handshake (one-entry output register)
//   dn_Idx         (only with AND_CNT_IDX_EN) compare-vector index since the
//                  last reference load
//
// Optional feature macro: AND_CNT_IDX_EN
module and_cnt #(
  parameter int unsigned VECTOR_WIDTH = 920,
  parameter int unsigned BUS_WIDTH    = 128,
  localparam int unsigned SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  localparam int unsigned CNT_WIDTH     = $clog2(BUS_WIDTH * SUB_VECTOR_NO)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BUS_WIDTH-1:0] up_SubVector,
  input  logic                 up_Valid,
  output logic                 up_Ready,
  input  logic [CNT_WIDTH-1:0] up_Cnt,
  input  logic                 up_CntNew,
  input  logic                 ref_Reload,
  output logic [CNT_WIDTH-1:0] dn_CntA,
  output logic [CNT_WIDTH-1:0] dn_CntB,
  output logic [CNT_WIDTH-1:0] dn_CntAB,
  output logic                 dn_Valid,
`ifdef AND_CNT_IDX_EN
  output logic [15:0]          dn_Idx,
`endif
  input  logic                 dn_Ready
);

  localparam int unsigned POP_WIDTH = $clog2(BUS_WIDTH + 1);
  localparam int unsigned IDX_WIDTH = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int unsigned LAST_BITS = VECTOR_WIDTH - (SUB_VECTOR_NO - 1) * BUS_WIDTH;
  // Valid bits of the last beat; padding above VECTOR_WIDTH never counts.
  localparam logic [BUS_WIDTH-1:0] LAST_MASK = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - LAST_BITS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(SUB_VECTOR_NO - 1);

  typedef enum logic {
    LOAD_REF,
    COMPARE
  } state_t;

  function automatic logic [POP_WIDTH-1:0] popcount(input logic [BUS_WIDTH-1:0] v);
    logic [POP_WIDTH-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
      s += POP_WIDTH'(v[i]);
    end
    return s;
  endfunction

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_a_q, cnt_a_d;
  logic [BUS_WIDTH-1:0]   ref_vec_q [SUB_VECTOR_NO];
  logic [BUS_WIDTH-1:0]   ref_vec_d [SUB_VECTOR_NO];
  logic [CNT_WIDTH-1:0]   dn_cnt_a_q, dn_cnt_a_d;
  logic [CNT_WIDTH-1:0]   dn_cnt_b_q, dn_cnt_b_d;
  logic [CNT_WIDTH-1:0]   dn_cnt_ab_q, dn_cnt_ab_d;
  logic                   dn_valid_q, dn_valid_d;

  logic                   accept;
  logic                   emit;
  logic [BUS_WIDTH-1:0]   beat_mask;
  logic [POP_WIDTH-1:0]   beat_pop;

  assign up_Ready  = rstn & (~dn_valid_q | dn_Ready);
  assign accept    = up_Valid & up_Ready;
  assign emit      = accept & up_CntNew & (state_q == COMPARE);
  assign beat_mask = (idx_q == LAST_IDX) ? LAST_MASK : '1;
  assign beat_pop  = popcount(up_SubVector & ref_vec_q[idx_q] & beat_mask);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cnt_a_d     = cnt_a_q;
    ref_vec_d   = ref_vec_q;
    dn_cnt_a_d  = dn_cnt_a_q;
    dn_cnt_b_d  = dn_cnt_b_q;
    dn_cnt_ab_d = dn_cnt_ab_q;
    // A consumed result drops unless a new one is loaded below.
    dn_valid_d  = dn_valid_q & ~dn_Ready;

    if (accept) begin
      // Early up_CntNew also restarts the beat index (partial vector).
      idx_d = (up_CntNew || idx_q == LAST_IDX) ? '0 : idx_q + IDX_WIDTH'(1);
      if (state_q == LOAD_REF) begin
        ref_vec_d[idx_q] = up_SubVector;
        if (up_CntNew) begin
          cnt_a_d = up_Cnt;
          state_d = COMPARE;
        end
      end else if (up_CntNew) begin
        dn_cnt_ab_d = acc_q + CNT_WIDTH'(beat_pop);
        dn_cnt_b_d  = up_Cnt;
        dn_cnt_a_d  = cnt_a_q;
        dn_valid_d  = 1'b1;
        acc_d       = '0;
        if (ref_Reload) begin
          state_d = LOAD_REF;
        end
      end else begin
        acc_d = acc_q + CNT_WIDTH'(beat_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= LOAD_REF;
      idx_q       <= '0;
      acc_q       <= '0;
      cnt_a_q     <= '0;
      dn_cnt_a_q  <= '0;
      dn_cnt_b_q  <= '0;
      dn_cnt_ab_q <= '0;
      dn_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      cnt_a_q     <= cnt_a_d;
      dn_cnt_a_q  <= dn_cnt_a_d;
      dn_cnt_b_q  <= dn_cnt_b_d;
      dn_cnt_ab_q <= dn_cnt_ab_d;
      dn_valid_q  <= dn_valid_d;
    end
  end

  // Reference storage needs no reset: it is always rewritten before use.
  always_ff @(posedge clk) begin
    ref_vec_q <= ref_vec_d;
  end

  assign dn_CntA  = dn_cnt_a_q;
  assign dn_CntB  = dn_cnt_b_q;
  assign dn_CntAB = dn_cnt_ab_q;
  assign dn_Valid = dn_valid_q;

`ifdef AND_CNT_IDX_EN
  logic [15:0] cmp_idx_q, cmp_idx_d;
  logic [15:0] dn_idx_q, dn_idx_d;

  always_comb begin
    cmp_idx_d = cmp_idx_q;
    dn_idx_d  = dn_idx_q;
    if (emit) begin
      dn_idx_d  = cmp_idx_q;
      cmp_idx_d = ref_Reload ? '0 : cmp_idx_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmp_idx_q <= '0;
      dn_idx_q  <= '0;
    end else begin
      cmp_idx_q <= cmp_idx_d;
      dn_idx_q  <= dn_idx_d;
    end
  end

  assign dn_Idx = dn_idx_q;
`endif

endmodule

// File: tb/tb_and_cnt.sv
// Bench for and_cnt (default VECTOR_WIDTH=920, BUS_WIDTH=128).
// The model works on whole 1024-bit vectors: it keeps reference A and
// predicts every result as plain popcounts of the valid 920 bits, queued
// in emission order. A negedge process compares every dn handshake against
// the queue, checks up_Ready and output stability while stalled.
module tb_and_cnt;

  localparam int W  = 128;
  localparam int NB = 8;
  localparam int VW = 920;
  localparam int TW = W * NB;

  logic          clk;
  logic          rstn;
  logic [W-1:0]  up_SubVector;
  logic          up_Valid;
  logic          up_Ready;
  logic [9:0]    up_Cnt;
  logic          up_CntNew;
  logic          ref_Reload;
  logic [9:0]    dn_CntA;
  logic [9:0]    dn_CntB;
  logic [9:0]    dn_CntAB;
  logic          dn_Valid;
  logic          dn_Ready;
`ifdef AND_CNT_IDX_EN
  logic [15:0]   dn_Idx;
`endif

  and_cnt #(.VECTOR_WIDTH(VW), .BUS_WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .up_SubVector (up_SubVector),
    .up_Valid     (up_Valid),
    .up_Ready     (up_Ready),
    .up_Cnt       (up_Cnt),
    .up_CntNew    (up_CntNew),
    .ref_Reload   (ref_Reload),
    .dn_CntA      (dn_CntA),
    .dn_CntB      (dn_CntB),
    .dn_CntAB     (dn_CntAB),
    .dn_Valid     (dn_Valid),
`ifdef AND_CNT_IDX_EN
    .dn_Idx       (dn_Idx),
`endif
    .dn_Ready     (dn_Ready)
  );

  typedef struct {
    int a;
    int b;
    int ab;
    int idx;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  // model state
  bit            m_is_ref;
  logic [TW-1:0] m_a;
  int            m_cnt_a;
  int            m_idx;

  bit rand_mode = 0;
  bit ready_man = 1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    dn_Ready = 1;
    forever begin
      @(posedge clk);
      #1;
      dn_Ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_man;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bits that count: the first nb beats, below VECTOR_WIDTH.
  function automatic logic [TW-1:0] valid_mask(input int nb);
    logic [TW-1:0] m;
    m = '0;
    for (int i = 0; i < TW; i++) if (i < VW && i < nb * W) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [TW-1:0] rnd_vec();
    logic [TW-1:0] v;
    for (int i = 0; i < TW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [TW-1:0] fill8(input logic [7:0] pat);
    logic [TW-1:0] v;
    for (int i = 0; i < TW / 8; i++) v[i*8 +: 8] = pat;
    return v;
  endfunction

  // Sends nb beats; up_CntNew on the last when mark_last. Bounded waits.
  task automatic send_vec(input logic [TW-1:0] v, input int nb, input bit mark_last,
                          input bit reload);
    int cnt;
    int n;
    cnt = $countones(v & valid_mask(nb));
    for (int b = 0; b < nb; b++) begin
      up_SubVector = v[b*W +: W];
      up_Valid     = 1'b1;
      up_Cnt       = 10'(cnt);
      up_CntNew    = mark_last && (b == nb - 1);
      ref_Reload   = reload;
      n = 0;
      @(negedge clk);
      while (!up_Ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (!up_Ready) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got up_Ready=0 expected 1 within 1000 cycles");
      end
      @(posedge clk);
      #1;
    end
    up_Valid   = 1'b0;
    up_CntNew  = 1'b0;
    ref_Reload = 1'b0;
    if (mark_last) begin
      if (m_is_ref) begin
        m_a      = v;
        m_cnt_a  = cnt;
        m_is_ref = 0;
      end else begin
        exp_q.push_back('{m_cnt_a, cnt, $countones(m_a & v & valid_mask(nb)), m_idx});
        m_idx = (m_idx + 1) % 65536;
        if (reload) begin
          m_is_ref = 1;
          m_idx    = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rstn     = 0;
    up_Valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dn_valid", int'(dn_Valid), 0);
    chk("rst_cnt_a", int'(dn_CntA), 0);
    chk("rst_cnt_b", int'(dn_CntB), 0);
    chk("rst_cnt_ab", int'(dn_CntAB), 0);
    chk("rst_up_ready", int'(up_Ready), 0);
    rstn = 1;
    m_is_ref = 1;
    m_idx    = 0;
    exp_q.delete();
    #1;
    chk("post_rst_up_ready", int'(up_Ready), 1);
  endtask

  // Compare process
  initial begin
    bit   held;
    int   ha, hb, hab;
    res_t e;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 0;
      end else begin
        chk("up_ready_rule", int'(up_Ready), int'(!dn_Valid || dn_Ready));
        if (held) begin
          chk("hold_cnt_a", int'(dn_CntA), ha);
          chk("hold_cnt_b", int'(dn_CntB), hb);
          chk("hold_cnt_ab", int'(dn_CntAB), hab);
        end
        if (dn_Valid && dn_Ready) begin
          held = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got ab=%0d expected no result", dn_CntAB);
          end else begin
            e = exp_q.pop_front();
            chk("res_cnt_a", int'(dn_CntA), e.a);
            chk("res_cnt_b", int'(dn_CntB), e.b);
            chk("res_cnt_ab", int'(dn_CntAB), e.ab);
`ifdef AND_CNT_IDX_EN
            chk("res_idx", int'(dn_Idx), e.idx);
`endif
          end
        end else if (dn_Valid) begin
          held = 1;
          ha   = int'(dn_CntA);
          hb   = int'(dn_CntB);
          hab  = int'(dn_CntAB);
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin
    logic [TW-1:0] ones, b3, p55, paa, r;
    int n;
    rstn = 0; up_Valid = 0; up_SubVector = '0; up_Cnt = '0; up_CntNew = 0; ref_Reload = 0;
    ones = '1;
    p55  = fill8(8'h55);
    paa  = fill8(8'hAA);
    b3   = ones;
    for (int i = 896; i < 920; i++) b3[i] = 1'b0;

    // 1: reset
    do_reset();

    // 2: all ones vs all ones, one-cycle latency
    send_vec(ones, NB, 1, 0);
    send_vec(ones, NB, 1, 0);
    chk("t2_valid", int'(dn_Valid), 1);
    chk("t2_cnt_a", int'(dn_CntA), 920);
    chk("t2_cnt_b", int'(dn_CntB), 920);
    chk("t2_cnt_ab", int'(dn_CntAB), 920);

    // 3: padding bits of the last beat must be masked; reload afterwards
    send_vec(b3, NB, 1, 1);
    chk("t3_cnt_b", int'(dn_CntB), 896);
    chk("t3_cnt_ab", int'(dn_CntAB), 896);

    // 4: alternating patterns; reference vector itself gives no output
    send_vec(p55, NB, 1, 0);
    chk("t4_ref_no_out", int'(dn_Valid), 0);
    send_vec(paa, NB, 1, 0);
    chk("t4_ab_zero", int'(dn_CntAB), 0);
    send_vec(p55, NB, 1, 0);
    chk("t4_cnt_a", int'(dn_CntA), 460);
    chk("t4_ab_self", int'(dn_CntAB), 460);

    // 5: back-pressure with a second vector pending
    ready_man = 0;
    @(posedge clk); #1;
    send_vec(ones, NB, 1, 0);
    fork
      send_vec(rnd_vec(), NB, 1, 0);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("t5_stall_ready", int'(up_Ready), 0);
        chk("t5_stall_valid", int'(dn_Valid), 1);
        chk("t5_stall_ab", int'(dn_CntAB), 460);
        ready_man = 1;
      end
    join
    rand_mode = 1;
    for (int k = 0; k < 6; k++) send_vec(rnd_vec(), NB, 1, 0);
    rand_mode = 0;
    ready_man = 1;
    repeat (3) @(posedge clk);
    #1;

    // 6: reload after B1 (idx 0,1,reload,0)
    send_vec(rnd_vec(), NB, 1, 0);
    send_vec(rnd_vec(), NB, 1, 1);
    r = rnd_vec();
    send_vec(r, NB, 1, 0);
    chk("t6_ref_no_out", int'(dn_Valid), 0);
    send_vec(r, NB, 1, 0);
    chk("t6_ab_self", int'(dn_CntAB), $countones(r & valid_mask(NB)));
`ifdef AND_CNT_IDX_EN
    chk("t6_idx_after_reload", int'(dn_Idx), 0);
`endif

    // 7: early up_CntNew gives partial-vector counts, then normal again
    send_vec(ones, 4, 1, 0);
    send_vec(rnd_vec(), NB, 1, 0);

    // 8: reset mid-vector discards it
    send_vec(rnd_vec(), 3, 0, 0);
    do_reset();
    send_vec(p55, NB, 1, 0);
    send_vec(ones, NB, 1, 0);
    chk("t8_ab", int'(dn_CntAB), 460);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
